div_issue_queue: RTL and testbench
==================================

Name: div_issue_queue

Overview:
Reservation station feeding the pipelined divider unit. It sits between rename/dispatch and the divider.
- Accepts dispatched divide/remainder ops carrying physical-register operand tags.
- Snoops the common data bus (CDB) to capture pending operands.
- Issues the oldest fully-ready entry to the divider as a one-cycle start pulse, with operands, destination tag, PC and op code.
It is the producer side of the divider's start/A/B/Physical_address/PC/op interface.

Parameters:
DEPTH, 8, number of queue entries (power of 2, 2..16)
TAG_W, 7, physical register tag width
XLEN, 32, operand/PC width
OP_W, 4, divider op code width (4'b0001 = quotient, any other value = remainder)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush; empties queue
dispatch_valid  in  1  new op offered
dispatch_ready  out  1  queue can accept this cycle
dispatch_op  in  OP_W  divider op code
dispatch_pc  in  XLEN  instruction PC
dispatch_dest  in  TAG_W  destination physical register
src_a_rdy  in  1  operand A value valid at dispatch
src_a_tag  in  TAG_W  operand A producer tag
src_a_val  in  XLEN  operand A value (used when src_a_rdy)
src_b_rdy  in  1  operand B value valid at dispatch
src_b_tag  in  TAG_W  operand B producer tag
src_b_val  in  XLEN  operand B value (used when src_b_rdy)
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast physical tag
cdb_value  in  XLEN  broadcast result
div_start  out  1  one-cycle issue pulse to divider
div_A  out  XLEN  dividend
div_B  out  XLEN  divisor
div_pa  out  TAG_W  destination tag to divider
div_pc  out  XLEN  PC to divider
div_op  out  OP_W  op code to divider
occupancy  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async): all entries invalid. div_start=0. div_A, div_B, div_pc=0. div_pa=0. div_op=0. occupancy=0. dispatch_ready=1.
- Entry fields: valid, op, pc, dest, and per operand {rdy, tag, val}, plus an age relation.
- Dispatch: accepted when dispatch_valid && dispatch_ready; written to any free entry.
- dispatch_ready = (occupancy < DEPTH), computed from registered state only. A same-cycle issue does not free space for a same-cycle dispatch.
- Dispatch-time bypass: if an operand is not rdy and cdb_valid && cdb_tag==src_x_tag in the dispatch cycle, the entry stores rdy=1, val=cdb_value.
- Wakeup: every cycle, each valid entry with operand not rdy and tag==cdb_tag under cdb_valid captures cdb_value and sets rdy. Both operands may wake in the same cycle.
- Ready: entry valid && A.rdy && B.rdy, evaluated on registered state.
  - A newly dispatched entry is issuable no earlier than the cycle after dispatch.
  - A CDB-woken entry is issuable the cycle after the broadcast.
- Select: among ready entries, the oldest by dispatch order; at most one issue per cycle. The divider is fully pipelined, so there is no backpressure.
- Issue, registered:
  - On the clock edge after selection, div_start=1 and div_A/div_B/div_pa/div_pc/div_op carry the selected entry's fields.
  - The entry is freed at that same edge.
  - Issue latency: ready at cycle N produces div_start at cycle N+1.
- No issue: div_start=0; data outputs hold their previous values.
- Age: strictly dispatch order, regardless of slot position or wakeup order. This holds under slot reuse and wrap-around.
- Flush: at the next edge all entries are invalidated, div_start=0 and occupancy=0.
  - flush has priority over same-cycle dispatch (dispatch dropped) and over issue (no pulse).
- Reset mid-operation: the queue empties immediately; pending entries are lost, and no div_start is generated.
- Divide-by-zero is not checked; operands pass unchanged.
- occupancy update per edge: +1 for accepted dispatch, −1 for issue; both in the same cycle gives a net 0.

Decomposition:
- Shared package div_pkg: OP_W, the DIV_OP_QUOT=4'b0001 constant, TAG_W, XLEN, and the entry struct/typedef.
- One natural sub-module: div_age_select. An age matrix plus a ready vector produces a one-hot oldest-ready grant; it is reusable for other issue queues.

Test Plan:
1. Dispatch op=0001, A=100 rdy, B=7 rdy at cycle 0 -> div_start=1 at cycle 2, div_A=100, div_B=7, div_op=0001, dest/pc echoed; occupancy 1 then 0.
2. Dispatch with B pending tag 0x15, then CDB tag 0x15 value 9 at cycle 3 -> no issue before cycle 4, div_start at cycle 5 with div_B=9.
3. Dispatch with A pending tag 0x22 while cdb_valid tag 0x22 value 55 in the same cycle -> bypass captured; issue two cycles later with div_A=55.
4. Fill 8 entries, all pending -> dispatch_ready=0, 9th dispatch ignored. Wake entries in reverse order in a single CDB cycle -> issues in dispatch order, one per cycle, 8 consecutive pulses.
5. Slot reuse/wrap: issue entries 0–3, redispatch four new ops, wake all -> old remaining entries issue before new ones.
6. Flush with 5 valid ready entries and a simultaneous dispatch -> next cycle occupancy=0, no div_start. Async reset asserted mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue queue.
//   DIV_OP_W / DIV_TAG_W / DIV_XLEN : field widths of a queue entry
//   DIV_OP_QUOT                      : op code selecting the quotient result
//   div_opnd_t / div_entry_t         : per-operand and per-entry state
//   opnd_snoop()                     : CDB capture for one operand
package div_pkg;

    localparam int DIV_OP_W  = 4;
    localparam int DIV_TAG_W = 7;
    localparam int DIV_XLEN  = 32;

    localparam logic [DIV_OP_W-1:0] DIV_OP_QUOT = 4'b0001;

    typedef struct packed {
        logic                 rdy;
        logic [DIV_TAG_W-1:0] tag;
        logic [DIV_XLEN-1:0]  val;
    } div_opnd_t;

    typedef struct packed {
        logic                 valid;
        logic [DIV_OP_W-1:0]  op;
        logic [DIV_XLEN-1:0]  pc;
        logic [DIV_TAG_W-1:0] dest;
        div_opnd_t            a;
        div_opnd_t            b;
    } div_entry_t;

    // A pending operand whose producer tag is on the CDB takes the broadcast value.
    function automatic div_opnd_t opnd_snoop(input div_opnd_t o, input logic cv,
                                             input logic [DIV_TAG_W-1:0] ct,
                                             input logic [DIV_XLEN-1:0] cval);
        div_opnd_t r;
        r = o;
        if (!o.rdy && cv && (o.tag == ct)) begin
            r.rdy = 1'b1;
            r.val = cval;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_age_select.sv
// Oldest-ready picker driven by an age matrix.
//   ready_i : per-entry ready vector
//   age_i   : age_i[i][j] = 1 when entry i is older than entry j
//   grant_o : one-hot (or zero) grant of the oldest ready entry
module div_age_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]        ready_i,
    input  logic [N-1:0][N-1:0] age_i,
    output logic [N-1:0]        grant_o
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [N-1:0] older_rdy;
        always_comb begin
            older_rdy = '0;
            for (int j = 0; j < N; j++)
                older_rdy[j] = (j != i) && ready_i[j] && age_i[j][i];
        end
        // Age is a strict total order over valid entries, so at most one lane wins.
        assign grant_o[i] = ready_i[i] && !(|older_rdy);
    end

endmodule

// File: rtl/div_issue_queue.sv
// Reservation station in front of the pipelined divider.
// Holds dispatched divide/remainder ops, snoops the CDB for missing operands and
// issues the oldest fully-ready entry as a registered one-cycle div_start pulse.
//   clk, reset (async, active-high), flush (sync, empties the queue)
//   dispatch_*  : op offer from rename/dispatch, dispatch_ready back-pressure
//   src_a_* / src_b_* : operand ready flag, producer tag, value
//   cdb_*       : result broadcast
//   div_*       : start pulse plus operands/dest/pc/op toward the divider
//   occupancy   : number of valid entries
// TAG_W/XLEN/OP_W must match the widths in div_pkg (entries are stored as div_entry_t).
module div_issue_queue
    import div_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = DIV_TAG_W,
    parameter int XLEN  = DIV_XLEN,
    parameter int OP_W  = DIV_OP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  logic [OP_W-1:0]          dispatch_op,
    input  logic [XLEN-1:0]          dispatch_pc,
    input  logic [TAG_W-1:0]         dispatch_dest,
    input  logic                     src_a_rdy,
    input  logic [TAG_W-1:0]         src_a_tag,
    input  logic [XLEN-1:0]          src_a_val,
    input  logic                     src_b_rdy,
    input  logic [TAG_W-1:0]         src_b_tag,
    input  logic [XLEN-1:0]          src_b_val,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [XLEN-1:0]          cdb_value,
    output logic                     div_start,
    output logic [XLEN-1:0]          div_A,
    output logic [XLEN-1:0]          div_B,
    output logic [TAG_W-1:0]         div_pa,
    output logic [XLEN-1:0]          div_pc,
    output logic [OP_W-1:0]          div_op,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    div_entry_t [DEPTH-1:0]            ent_q, ent_d;
    logic       [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    logic       [CNT_W-1:0]            occ_q, occ_d;
    logic       [DEPTH-1:0]            ready, grant;
    logic       [IDX_W-1:0]            alloc_idx, sel_idx;
    logic                              disp_acc, issue;

    logic             start_q;
    logic [XLEN-1:0]  a_q, b_q, pc_q;
    logic [TAG_W-1:0] pa_q;
    logic [OP_W-1:0]  op_q;

    // Readiness comes from registered state only: a dispatch or wakeup this
    // cycle becomes issuable next cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ready[i] = ent_q[i].valid && ent_q[i].a.rdy && ent_q[i].b.rdy;
    end

    div_age_select #(.N(DEPTH)) u_sel (
        .ready_i (ready),
        .age_i   (age_q),
        .grant_o (grant)
    );

    // Lowest free slot / index of the one-hot grant (descending loop: lowest wins).
    always_comb begin
        alloc_idx = '0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) alloc_idx = i[IDX_W-1:0];
            if (grant[i])        sel_idx   = i[IDX_W-1:0];
        end
    end

    assign dispatch_ready = (occ_q < CNT_W'(DEPTH));
    assign disp_acc       = dispatch_valid && dispatch_ready;
    assign issue          = |grant;

    always_comb begin
        ent_d = ent_q;
        age_d = age_q;
        occ_d = occ_q + CNT_W'(disp_acc) - CNT_W'(issue);

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                ent_d[i].a = opnd_snoop(ent_q[i].a, cdb_valid, cdb_tag, cdb_value);
                ent_d[i].b = opnd_snoop(ent_q[i].b, cdb_valid, cdb_tag, cdb_value);
            end
        end

        if (issue) ent_d[sel_idx].valid = 1'b0;

        if (disp_acc) begin
            ent_d[alloc_idx].valid = 1'b1;
            ent_d[alloc_idx].op    = dispatch_op;
            ent_d[alloc_idx].pc    = dispatch_pc;
            ent_d[alloc_idx].dest  = dispatch_dest;
            ent_d[alloc_idx].a     = opnd_snoop('{rdy: src_a_rdy, tag: src_a_tag, val: src_a_val},
                                                cdb_valid, cdb_tag, cdb_value);
            ent_d[alloc_idx].b     = opnd_snoop('{rdy: src_b_rdy, tag: src_b_tag, val: src_b_val},
                                                cdb_valid, cdb_tag, cdb_value);
            // Newcomer is younger than everything: clear its row, set its column.
            for (int j = 0; j < DEPTH; j++) begin
                age_d[alloc_idx][j] = 1'b0;
                if (j != int'(alloc_idx)) age_d[j][alloc_idx] = 1'b1;
            end
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q   <= '0;
            age_q   <= '0;
            occ_q   <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            pc_q    <= '0;
            pa_q    <= '0;
            op_q    <= '0;
        end else begin
            ent_q   <= ent_d;
            age_q   <= age_d;
            occ_q   <= occ_d;
            start_q <= issue && !flush;
            if (issue && !flush) begin
                a_q  <= ent_q[sel_idx].a.val;
                b_q  <= ent_q[sel_idx].b.val;
                pc_q <= ent_q[sel_idx].pc;
                pa_q <= ent_q[sel_idx].dest;
                op_q <= ent_q[sel_idx].op;
            end
        end
    end

    assign div_start = start_q;
    assign div_A     = a_q;
    assign div_B     = b_q;
    assign div_pc    = pc_q;
    assign div_pa    = pa_q;
    assign div_op    = op_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue: dispatch/issue latency, CDB wakeup,
// dispatch-time bypass, full queue, age order under slot reuse, flush, reset.
module tb_div_issue_queue;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, dispatch_valid, dispatch_ready;
    logic [3:0]  dispatch_op;
    logic [31:0] dispatch_pc;
    logic [6:0]  dispatch_dest;
    logic        src_a_rdy, src_b_rdy;
    logic [6:0]  src_a_tag, src_b_tag;
    logic [31:0] src_a_val, src_b_val;
    logic        cdb_valid;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        div_start;
    logic [31:0] div_A, div_B, div_pc;
    logic [6:0]  div_pa;
    logic [3:0]  div_op;
    logic [3:0]  occupancy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op), .dispatch_pc(dispatch_pc), .dispatch_dest(dispatch_dest),
        .src_a_rdy(src_a_rdy), .src_a_tag(src_a_tag), .src_a_val(src_a_val),
        .src_b_rdy(src_b_rdy), .src_b_tag(src_b_tag), .src_b_val(src_b_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .div_start(div_start), .div_A(div_A), .div_B(div_B), .div_pa(div_pa),
        .div_pc(div_pc), .div_op(div_op), .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] pc, input logic [6:0] dest,
                        input logic ar, input logic [6:0] at, input logic [31:0] av,
                        input logic br, input logic [6:0] bt, input logic [31:0] bv);
        dispatch_valid = 1'b1;
        dispatch_op    = op;
        dispatch_pc    = pc;
        dispatch_dest  = dest;
        src_a_rdy = ar; src_a_tag = at; src_a_val = av;
        src_b_rdy = br; src_b_tag = bt; src_b_val = bv;
    endtask

    task automatic cdb(input logic [6:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_value = v;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        disp(4'h0, 32'h0, 7'h0, 1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0);
        dispatch_valid = 1'b0;
        cdb_tag = 7'h0; cdb_value = 32'h0;
        #12;
        chk("rst_start", div_start, 0);
        chk("rst_A", div_A, 0);
        chk("rst_pa", div_pa, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ready", dispatch_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1: both operands ready at dispatch -> pulse two edges later
        disp(DIV_OP_QUOT, 32'h1000, 7'h0A, 1'b1, 7'h01, 32'd100, 1'b1, 7'h02, 32'd7);
        tick(); idle();
        chk("t1_occ1", occupancy, 1);
        chk("t1_nostart", div_start, 0);
        tick();
        chk("t1_start", div_start, 1);
        chk("t1_A", div_A, 100);
        chk("t1_B", div_B, 7);
        chk("t1_op", div_op, 4'b0001);
        chk("t1_pa", div_pa, 7'h0A);
        chk("t1_pc", div_pc, 32'h1000);
        chk("t1_occ0", occupancy, 0);
        tick();
        chk("t1_pulse_end", div_start, 0);
        chk("t1_A_hold", div_A, 100);

        // 2: B waits on tag 0x15, broadcast in cycle 3
        disp(4'h2, 32'h2000, 7'h0B, 1'b1, 7'h03, 32'd20, 1'b0, 7'h15, 32'hDEAD);
        tick(); idle();
        cdb(7'h16, 32'd77);              // unrelated tag must not wake it
        chk("t2_c1", div_start, 0);
        tick(); idle();
        chk("t2_c2", div_start, 0);
        tick();
        cdb(7'h15, 32'd9);
        chk("t2_c3", div_start, 0);
        tick(); idle();
        chk("t2_c4", div_start, 0);
        tick();
        chk("t2_c5_start", div_start, 1);
        chk("t2_B", div_B, 9);
        chk("t2_A", div_A, 20);
        chk("t2_op", div_op, 2);
        tick();

        // 3: dispatch-time bypass of A from the CDB
        disp(4'h1, 32'h3000, 7'h0C, 1'b0, 7'h22, 32'h0, 1'b1, 7'h04, 32'd5);
        cdb(7'h22, 32'd55);
        tick(); idle();
        chk("t3_c1", div_start, 0);
        tick();
        chk("t3_start", div_start, 1);
        chk("t3_A", div_A, 55);
        chk("t3_B", div_B, 5);
        tick();

        // 4: fill all 8 with A pending on tag 0x30; 9th dispatch refused
        for (int k = 0; k < 8; k++) begin
            disp(4'h3, 32'h4000 + 32'(k), 7'(8'h40 + k), 1'b0, 7'h30, 32'h0,
                 1'b1, 7'h05, 32'(k + 1));
            tick();
        end
        idle();
        chk("t4_full_occ", occupancy, 8);
        chk("t4_full_ready", dispatch_ready, 0);
        disp(4'h3, 32'h4999, 7'h7F, 1'b0, 7'h30, 32'h0, 1'b1, 7'h05, 32'd99);
        tick(); idle();
        chk("t4_9th_dropped", occupancy, 8);
        cdb(7'h30, 32'h99);
        tick(); idle();
        chk("t4_wake_nostart", div_start, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t4_start", div_start, 1);
            chk("t4_pa", div_pa, 64'h40 + 64'(k));
            chk("t4_B", div_B, 64'(k + 1));
        end
        tick();
        chk("t4_done_start", div_start, 0);
        chk("t4_done_occ", occupancy, 0);

        // 5: slot reuse; slots 0-3 wait on 0x31, 4-7 on 0x32
        for (int k = 0; k < 8; k++) begin
            disp(4'h4, 32'h5000, 7'(8'h50 + k), 1'b0, (k < 4) ? 7'h31 : 7'h32, 32'h0,
                 1'b1, 7'h06, 32'd3);
            tick();
        end
        idle();
        cdb(7'h31, 32'd11);
        tick(); idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_first_pa", div_pa, 64'h50 + 64'(k));
        end
        tick();
        chk("t5_occ4", occupancy, 4);
        for (int k = 0; k < 4; k++) begin
            disp(4'h4, 32'h5100, 7'(8'h58 + k), 1'b0, 7'h32, 32'h0, 1'b1, 7'h06, 32'd3);
            tick();
        end
        idle();
        cdb(7'h32, 32'd12);
        tick(); idle();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t5_start", div_start, 1);
            chk("t5_order_pa", div_pa, 64'h54 + 64'(k));
        end
        tick();
        chk("t5_done_occ", occupancy, 0);

        // 6a: flush beats issue and a same-cycle dispatch
        for (int k = 0; k < 5; k++) begin
            disp(4'h1, 32'h6000, 7'(8'h60 + k), 1'b0, 7'h33, 32'h0, 1'b1, 7'h07, 32'd2);
            tick();
        end
        idle();
        cdb(7'h33, 32'd13);
        tick(); idle();
        chk("t6_pre_occ", occupancy, 5);
        flush = 1'b1;
        disp(4'h1, 32'h6100, 7'h6F, 1'b1, 7'h0, 32'd1, 1'b1, 7'h0, 32'd1);
        tick(); idle();
        chk("t6_flush_start", div_start, 0);
        chk("t6_flush_occ", occupancy, 0);
        chk("t6_flush_ready", dispatch_ready, 1);
        tick();
        chk("t6_flush_quiet", div_start, 0);

        // 6b: simultaneous issue + dispatch nets 0, then async reset mid-stream
        disp(4'h1, 32'h7000, 7'h70, 1'b1, 7'h0, 32'd40, 1'b1, 7'h0, 32'd4);
        tick();
        disp(4'h1, 32'h7004, 7'h71, 1'b1, 7'h0, 32'd41, 1'b1, 7'h0, 32'd4);
        tick(); idle();
        chk("t6_net0_occ", occupancy, 1);
        chk("t6_pre_rst_start", div_start, 1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_start", div_start, 0);
        chk("t6_rst_A", div_A, 0);
        chk("t6_rst_pa", div_pa, 0);
        chk("t6_rst_occ", occupancy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        chk("t6_post_rst_start", div_start, 0);
        chk("t6_post_rst_occ", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
